// File: rtl/alu_seq_driver_if.sv
// Control bus between the sequence driver and the regfile/ALU datapath.
// The driver is master; the datapath returns port-A read data.
interface alu_seq_driver_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int OP_W   = 8
);
    logic              reg_reset;
    logic              write_enable;
    logic [ADDR_W-1:0] write_select;
    logic [ADDR_W-1:0] regA;
    logic [ADDR_W-1:0] regB;
    logic [OP_W-1:0]   op;
    logic              reg_imm;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output reg_reset, write_enable, write_select,
        output regA, regB, op, reg_imm, imm,
        input  rd_data
    );

    modport slave (
        input  reg_reset, write_enable, write_select,
        input  regA, regB, op, reg_imm, imm,
        output rd_data
    );
endinterface

// File: rtl/alu_seq_driver.sv
// Fills every register with a Fibonacci or arithmetic sequence through the
// ALU, then reads each back against a two-entry running model.
module alu_seq_driver #(
    parameter int              NUM_REGS = 16,
    parameter int              ADDR_W   = 4,
    parameter int              DATA_W   = 16,
    parameter int              OP_W     = 8,
    parameter logic [OP_W-1:0] OP_NOP   = 8'h00,
    parameter logic [OP_W-1:0] OP_ADD   = 8'h05,
    parameter logic [OP_W-1:0] OP_ADDI  = 8'h50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    alu_seq_driver_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_index
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SEED0, S_SEED1, S_COMPUTE, S_CHECK, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] k;
    logic              mode_q;
    logic [DATA_W-1:0] seed0_q, seed1_q;
    logic [DATA_W-1:0] hist0, hist1, expected;
    logic              take_start;

    assign take_start = start && (state == S_IDLE || state == S_DONE);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_CLEAR;
            S_CLEAR:   state_nxt = S_SEED0;
            S_SEED0:   state_nxt = S_SEED1;
            S_SEED1:   state_nxt = S_COMPUTE;
            S_COMPUTE: if (k == K_LAST) state_nxt = S_CHECK;
            S_CHECK:   if (k == K_LAST) state_nxt = S_DONE;
            S_DONE:    if (start) state_nxt = S_CLEAR;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // hist0/hist1 hold E[k-2]/E[k-1] as CHECK walks upward
    always_comb begin
        if (k == '0)                 expected = seed0_q;
        else if (k == ADDR_W'(1))    expected = seed1_q;
        else if (mode_q)             expected = hist1 + seed1_q;
        else                         expected = hist0 + hist1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k          <= '0;
            mode_q     <= 1'b0;
            seed0_q    <= '0;
            seed1_q    <= '0;
            hist0      <= '0;
            hist1      <= '0;
            pass       <= 1'b0;
            fail_index <= '0;
        end else begin
            if (take_start) begin
                mode_q     <= mode;
                seed0_q    <= seed0;
                seed1_q    <= seed1;
                pass       <= 1'b1;
                fail_index <= '0;
            end
            case (state)
                S_SEED1:   k <= ADDR_W'(2);
                S_COMPUTE: k <= (k == K_LAST) ? '0 : k + 1'b1;
                S_CHECK: begin
                    k     <= k + 1'b1;
                    hist0 <= hist1;
                    hist1 <= expected;
                    if (pass && bus.rd_data != expected) begin
                        pass       <= 1'b0;
                        fail_index <= k;
                    end
                end
                default:   k <= '0;
            endcase
        end
    end

    always_comb begin
        bus.reg_reset    = 1'b0;
        bus.write_enable = 1'b0;
        bus.write_select = '0;
        bus.regA         = '0;
        bus.regB         = '0;
        bus.op           = OP_NOP;
        bus.reg_imm      = 1'b0;
        bus.imm          = '0;
        busy             = 1'b1;
        case (state)
            S_CLEAR: bus.reg_reset = 1'b1;
            S_SEED0: begin
                bus.op           = OP_ADDI;
                bus.reg_imm      = 1'b1;
                bus.imm          = seed0_q;
                bus.write_enable = 1'b1;
            end
            S_SEED1: begin
                bus.op           = OP_ADDI;
                bus.reg_imm      = 1'b1;
                bus.imm          = seed1_q;
                bus.regA         = ADDR_W'(1);
                bus.write_select = ADDR_W'(1);
                bus.write_enable = 1'b1;
            end
            S_COMPUTE: begin
                bus.op           = OP_ADD;
                bus.write_enable = 1'b1;
                bus.write_select = k;
                bus.regA = mode_q ? k - ADDR_W'(1) : k - ADDR_W'(2);
                bus.regB = mode_q ? ADDR_W'(1) : k - ADDR_W'(1);
            end
            S_CHECK:  bus.regA = k;
            default:  busy = 1'b0;
        endcase
    end

endmodule
